simon_enc: RTL

SIMON_ENC -- requirements
Module: simon_enc

---
 rtl/simon_pkg.sv | 19 +
 rtl/simon_round.sv | 33 +++
 rtl/simon_enc.sv | 111 +++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon 128/256 datapath.
//   WORD      - Simon word width (two words form one block)
//   ROUNDS    - number of encryption rounds
//   KEY_ADR_W - width of the round-key address bus
//   state_t   - control FSM state encoding
package simon_pkg;

  localparam int WORD      = 64;
  localparam int ROUNDS    = 72;
  localparam int KEY_ADR_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/simon_round.sv
// One Simon Feistel round, purely combinational.
//   x, y  - current half-blocks
//   k     - round key
//   x_new - y ^ f(x) ^ k, with f(x) = (x<<<1 & x<<<8) ^ (x<<<2)
//   y_new - x
// Kept separate so a decryptor can reuse the same round function.
module simon_round
  import simon_pkg::*;
#(
  parameter int W = WORD
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] k,
  output logic [W-1:0] x_new,
  output logic [W-1:0] y_new
);

  logic [W-1:0] rot1;
  logic [W-1:0] rot2;
  logic [W-1:0] rot8;
  logic [W-1:0] f;

  // Left rotations are plain rewiring, modulo the word width.
  assign rot1 = {x[W-2:0], x[W-1]};
  assign rot2 = {x[W-3:0], x[W-1:W-2]};
  assign rot8 = {x[W-9:0], x[W-1:W-8]};

  assign f     = (rot1 & rot8) ^ rot2;
  assign x_new = y ^ f ^ k;
  assign y_new = x;

endmodule

// File: rtl/simon_enc.sv
// Iterative Simon 128/256 block encryptor, one round per clock.
//   clk       - clock, all state on rising edge
//   res_n     - asynchronous active-low reset
//   start     - request to encrypt `in` (honoured only in IDLE with key_ready)
//   key_ready - external round-key store is fully populated
//   key       - round key read combinationally at key_adr
//   key_adr   - round-key address (current round in RUN, else 0)
//   in        - plaintext {x, y}
//   out       - ciphertext register {x, y}, held until the next result
//   busy      - block in flight (LOAD, RUN, FIN)
//   done      - one-cycle pulse when out has been updated
// Start-to-done latency is ROUNDS+2 edges; back-to-back period ROUNDS+3.
module simon_enc
  import simon_pkg::*;
#(
  parameter int ROUNDS = simon_pkg::ROUNDS,
  parameter int WORD   = simon_pkg::WORD
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 start,
  input  logic                 key_ready,
  input  logic [WORD-1:0]      key,
  output logic [KEY_ADR_W-1:0] key_adr,
  input  logic [2*WORD-1:0]    in,
  output logic [2*WORD-1:0]    out,
  output logic                 busy,
  output logic                 done
);

  localparam logic [KEY_ADR_W-1:0] LAST_RND = KEY_ADR_W'(ROUNDS - 1);

  state_t                 state_reg;
  state_t                 state_next;
  logic [KEY_ADR_W-1:0]   rnd_reg;
  logic [WORD-1:0]        x_reg;
  logic [WORD-1:0]        y_reg;
  logic [2*WORD-1:0]      out_reg;
  logic                   done_reg;
  logic [WORD-1:0]        x_round;
  logic [WORD-1:0]        y_round;

  simon_round #(
    .W(WORD)
  ) u_round (
    .x     (x_reg),
    .y     (y_reg),
    .k     (key),
    .x_new (x_round),
    .y_new (y_round)
  );

  // Next-state logic. The 2-bit encoding is fully used, but the default
  // still steers any corrupted value back to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start && key_ready) state_next = LOAD;
      LOAD:    state_next = RUN;
      RUN:     if (rnd_reg == LAST_RND) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state register. key_adr is forced to 0
  // outside RUN so the key store sees a stable address while idle.
  always_comb begin
    busy    = 1'b0;
    key_adr = '0;
    if (state_reg != IDLE) busy = 1'b1;
    if (state_reg == RUN)  key_adr = rnd_reg;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_reg <= IDLE;
      rnd_reg   <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      out_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        LOAD: begin
          // The only point where the plaintext port is sampled.
          x_reg   <= in[2*WORD-1:WORD];
          y_reg   <= in[WORD-1:0];
          rnd_reg <= '0;
        end
        RUN: begin
          x_reg   <= x_round;
          y_reg   <= y_round;
          rnd_reg <= rnd_reg + 1'b1;
        end
        FIN: begin
          out_reg  <= {x_reg, y_reg};
          done_reg <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign out  = out_reg;
  assign done = done_reg;

endmodule
